// File: rtl/isa_arb_pkg.sv
// Shared types and constants for the ISA bus arbiter: FSM states, default
// DMA phase lengths, channel geometry and the channel priority encoder.
package isa_arb_pkg;

    localparam int unsigned NUM_CHAN = 4;
    localparam int unsigned COUNT_W  = 16;
    localparam int unsigned CH_W     = $clog2(NUM_CHAN);
    localparam int unsigned PHASE_W  = 4;

    localparam int unsigned DEF_SETUP_CYCLES   = 2;
    localparam int unsigned DEF_XFER_CYCLES    = 4;
    localparam int unsigned DEF_RECOVER_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_IO          = 3'd1,
        ST_DMA_SETUP   = 3'd2,
        ST_DMA_XFER    = 3'd3,
        ST_DMA_RECOVER = 3'd4
    } state_e;

    // Lowest set bit wins, so channel 0 has the highest priority.
    function automatic logic [CH_W-1:0] lowest_index(input logic [NUM_CHAN-1:0] req);
        lowest_index = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (req[i]) lowest_index = CH_W'(i);
        end
    endfunction

endpackage

// File: rtl/isa_sync.sv
// Two-flop synchroniser for asynchronous level inputs, one flop pair per bit.
module isa_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // their inputs from the same edge; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/isa_bus_arbiter.sv
// Shares the ISA bus between HPS I/O cycles and single-transfer DMA cycles on
// four channels, with per-channel transfer counts and terminal-count signalling.
module isa_bus_arbiter
    import isa_arb_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
    parameter int unsigned XFER_CYCLES    = DEF_XFER_CYCLES,
    parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CHAN-1:0] drq,
    input  logic [NUM_CHAN-1:0] chan_enable,
    input  logic [NUM_CHAN-1:0] count_load,
    input  logic [COUNT_W-1:0]  count_value,
    input  logic                io_req,
    input  logic                io_done,
    output logic                io_gnt,
    output logic                aen,
    output logic [NUM_CHAN-1:0] dack_n,
    output logic [CH_W-1:0]     dma_ch,
    output logic                xfer_strobe,
    output logic                tc,
    output logic [NUM_CHAN-1:0] chan_done
);

    localparam logic [PHASE_W-1:0] SETUP_LAST   = PHASE_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] XFER_LAST    = PHASE_W'(XFER_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RECOVER_LAST = PHASE_W'(RECOVER_CYCLES - 1);

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic                 hps_turn_q, hps_turn_d;
    logic [COUNT_W-1:0]   count_q [NUM_CHAN];
    logic [NUM_CHAN-1:0]  chan_done_q;
    logic                 io_gnt_q, aen_q, xfer_strobe_q, tc_q;
    logic [NUM_CHAN-1:0]  dack_n_q;

    logic [NUM_CHAN-1:0]  drq_sync;
    logic [NUM_CHAN-1:0]  eligible;
    logic                 last_xfer;
    logic                 tc_d;

    isa_sync #(.WIDTH(NUM_CHAN)) u_drq_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (drq),
        .q_o   (drq_sync)
    );

    assign eligible  = drq_sync & chan_enable & ~chan_done_q;
    assign last_xfer = (state_q == ST_DMA_XFER) && (phase_q == '0);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which is what keeps this block from inferring latches.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        ch_d       = ch_q;
        hps_turn_d = hps_turn_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io_req && (hps_turn_q || eligible == '0)) begin
                    state_d = ST_IO;
                end else if (eligible != '0) begin
                    state_d = ST_DMA_SETUP;
                    phase_d = SETUP_LAST;
                    ch_d    = lowest_index(eligible);
                end
            end
            ST_IO: begin
                if (io_done) begin
                    state_d    = ST_IDLE;
                    hps_turn_d = 1'b0;
                end
            end
            ST_DMA_SETUP: begin
                if (phase_q == '0) begin
                    state_d = ST_DMA_XFER;
                    phase_d = XFER_LAST;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_DMA_XFER: begin
                if (phase_q == '0) begin
                    state_d = ST_DMA_RECOVER;
                    phase_d = RECOVER_LAST;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            ST_DMA_RECOVER: begin
                if (phase_q == '0) begin
                    state_d    = ST_IDLE;
                    hps_turn_d = 1'b1;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from next state, so tc looks ahead to the last XFER clock.
    assign tc_d = (state_d == ST_DMA_XFER) && (phase_d == '0) &&
                  (count_q[ch_d] == COUNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            ch_q          <= '0;
            hps_turn_q    <= 1'b0;
            io_gnt_q      <= 1'b0;
            aen_q         <= 1'b0;
            dack_n_q      <= '1;
            xfer_strobe_q <= 1'b0;
            tc_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            ch_q          <= ch_d;
            hps_turn_q    <= hps_turn_d;
            io_gnt_q      <= (state_d == ST_IO);
            aen_q         <= (state_d == ST_DMA_SETUP) || (state_d == ST_DMA_XFER);
            dack_n_q      <= (state_d == ST_DMA_XFER) ?
                             ~({{(NUM_CHAN-1){1'b0}}, 1'b1} << ch_d) : '1;
            xfer_strobe_q <= (state_d == ST_DMA_XFER);
            tc_q          <= tc_d;
        end
    end

    // NOTE: the count registers are a small flop array, not a RAM, so they are
    // reset like any other state; a done flag set at reset keeps them idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHAN; i++) count_q[i] <= '0;
            chan_done_q <= '1;
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (count_load[i]) begin
                    count_q[i]     <= count_value;
                    chan_done_q[i] <= (count_value == '0);
                end else if (last_xfer && ch_q == CH_W'(i) && count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - 1'b1;
                    if (count_q[i] == COUNT_W'(1)) chan_done_q[i] <= 1'b1;
                end
            end
        end
    end

    assign io_gnt      = io_gnt_q;
    assign aen         = aen_q;
    assign dack_n      = dack_n_q;
    assign dma_ch      = ch_q;
    assign xfer_strobe = xfer_strobe_q;
    assign tc          = tc_q;
    assign chan_done   = chan_done_q;

endmodule
